// File: rtl/dmi_jtag_pkg.sv
// Shared types and IR codes for the RISC-V debug JTAG TAP.
// Range helper is used at elaboration to reject bad user-chain IR ranges.
package dmi_jtag_pkg;

   typedef enum logic [3:0] {
      TestLogicReset = 4'h0,
      RunTestIdle    = 4'h1,
      SelectDrScan   = 4'h2,
      CaptureDr      = 4'h3,
      ShiftDr        = 4'h4,
      Exit1Dr        = 4'h5,
      PauseDr        = 4'h6,
      Exit2Dr        = 4'h7,
      UpdateDr       = 4'h8,
      SelectIrScan   = 4'h9,
      CaptureIr      = 4'hA,
      ShiftIr        = 4'hB,
      Exit1Ir        = 4'hC,
      PauseIr        = 4'hD,
      Exit2Ir        = 4'hE,
      UpdateIr       = 4'hF
   } tap_state_e;

   typedef struct packed {
      logic [13:0] zero1;
      logic        dmihardreset;
      logic        dmireset;
      logic        zero0;
      logic [2:0]  idle;
      logic [1:0]  dmistat;
      logic [5:0]  abits;
      logic [3:0]  version;
   } dtmcs_t;

   localparam logic [4:0] BYPASS0   = 5'h00;
   localparam logic [4:0] IDCODE    = 5'h01;
   localparam logic [4:0] DTMCSR    = 5'h10;
   localparam logic [4:0] DMIACCESS = 5'h11;

   // User chain codes must not collide with the fixed instructions nor reach all-ones.
   function automatic bit user_range_ok(int base, int num, int ir_len);
      int code;
      bit ok;
      ok = 1'b1;
      for (int i = 0; i < num; i++) begin
         code = base + i;
         if (code == 0 || code == 1 || code == 16 || code == 17 || code >= (1 << ir_len) - 1) begin
            ok = 1'b0;
         end
      end
      return ok;
   endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller: 16-state register advanced by tms_i on rising tck,
// with decoded state strobes for the datapath.
module jtag_tap_fsm
   import dmi_jtag_pkg::*;
(
   input  logic tck_i,
   input  logic trst_ni,
   input  logic tms_i,
   output logic test_logic_reset_o,
   output logic capture_dr_o,
   output logic shift_dr_o,
   output logic update_dr_o,
   output logic capture_ir_o,
   output logic shift_ir_o,
   output logic update_ir_o
);

   tap_state_e state_d, state_q;

   // Next-state function of the standard TAP graph
   always_comb begin
      state_d = state_q;
      case (state_q)
         TestLogicReset: state_d = tms_i ? TestLogicReset : RunTestIdle;
         RunTestIdle:    state_d = tms_i ? SelectDrScan   : RunTestIdle;
         SelectDrScan:   state_d = tms_i ? SelectIrScan   : CaptureDr;
         CaptureDr:      state_d = tms_i ? Exit1Dr        : ShiftDr;
         ShiftDr:        state_d = tms_i ? Exit1Dr        : ShiftDr;
         Exit1Dr:        state_d = tms_i ? UpdateDr       : PauseDr;
         PauseDr:        state_d = tms_i ? Exit2Dr        : PauseDr;
         Exit2Dr:        state_d = tms_i ? UpdateDr       : ShiftDr;
         UpdateDr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
         SelectIrScan:   state_d = tms_i ? TestLogicReset : CaptureIr;
         CaptureIr:      state_d = tms_i ? Exit1Ir        : ShiftIr;
         ShiftIr:        state_d = tms_i ? Exit1Ir        : ShiftIr;
         Exit1Ir:        state_d = tms_i ? UpdateIr       : PauseIr;
         PauseIr:        state_d = tms_i ? Exit2Ir        : PauseIr;
         Exit2Ir:        state_d = tms_i ? UpdateIr       : ShiftIr;
         UpdateIr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
         default:        state_d = TestLogicReset;
      endcase
   end

   // State register
   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         state_q <= TestLogicReset;
      end else begin
         state_q <= state_d;
      end
   end

   assign test_logic_reset_o = (state_q == TestLogicReset);
   assign capture_dr_o       = (state_q == CaptureDr);
   assign shift_dr_o         = (state_q == ShiftDr);
   assign update_dr_o        = (state_q == UpdateDr);
   assign capture_ir_o       = (state_q == CaptureIr);
   assign shift_ir_o         = (state_q == ShiftIr);
   assign update_ir_o        = (state_q == UpdateIr);

endmodule

// File: rtl/tc_clk_cells.sv
// Technology clock cells: inverter and 2:1 mux, replaced by hardened cells in the
// target library.
module tc_clk_inverter (
   input  logic clk_i,
   output logic clk_o
);
   assign clk_o = ~clk_i;
endmodule

module tc_clk_mux2 (
   input  logic clk0_i,
   input  logic clk1_i,
   input  logic clk_sel_i,
   output logic clk_o
);
   assign clk_o = clk_sel_i ? clk1_i : clk0_i;
endmodule

// File: rtl/dmi_jtag_tap_mc.sv
// JTAG TAP for the RISC-V debug transport: IR, IDCODE/BYPASS/DTMCS registers,
// DMI and user-chain select decode, and the falling-edge TDO stage.
module dmi_jtag_tap_mc
   import dmi_jtag_pkg::*;
#(
   parameter int          IrLength    = 5,
   parameter logic [31:0] IdcodeValue = 32'h00000001,
   parameter int          NumChains   = 2,
   parameter int          UserIrBase  = 32'h12,
   parameter int          DmiAbits    = 7,
   parameter int          IdleHint    = 1
) (
   input  logic                 tck_i,
   input  logic                 trst_ni,
   input  logic                 tms_i,
   input  logic                 td_i,
   output logic                 td_o,
   output logic                 tdo_oe_o,
   input  logic                 testmode_i,
   output logic                 test_logic_reset_o,
   output logic                 capture_dr_o,
   output logic                 shift_dr_o,
   output logic                 update_dr_o,
   output logic                 dmi_access_o,
   output logic                 dmi_reset_o,
   output logic                 dmi_hardreset_o,
   input  logic [1:0]           dmi_error_i,
   output logic                 dmi_tdi_o,
   input  logic                 dmi_tdo_i,
   output logic [NumChains-1:0] chain_select_o,
   input  logic [NumChains-1:0] chain_tdo_i
);

   if (IrLength < 5) begin : g_bad_irlength
      $fatal(1, "dmi_jtag_tap_mc: IrLength must be >= 5");
   end
   if (IdcodeValue[0] != 1'b1) begin : g_bad_idcode
      $fatal(1, "dmi_jtag_tap_mc: IdcodeValue bit 0 must be 1");
   end
   if (NumChains < 1 || NumChains > 8) begin : g_bad_numchains
      $fatal(1, "dmi_jtag_tap_mc: NumChains must be 1..8");
   end
   if (!user_range_ok(UserIrBase, NumChains, IrLength)) begin : g_bad_userbase
      $fatal(1, "dmi_jtag_tap_mc: user chain IR range collides with reserved codes");
   end

   localparam logic [IrLength-1:0] IrIdcode  = IrLength'(IDCODE);
   localparam logic [IrLength-1:0] IrDtmcs   = IrLength'(DTMCSR);
   localparam logic [IrLength-1:0] IrDmi     = IrLength'(DMIACCESS);
   localparam logic [IrLength-1:0] IrCapture = IrLength'(5'b00101);
   localparam logic [5:0]          AbitsVal  = 6'(DmiAbits);
   localparam logic [2:0]          IdleVal   = 3'(IdleHint);

   logic tlr_s, cap_dr_s, sh_dr_s, upd_dr_s, cap_ir_s, sh_ir_s, upd_ir_s;
   logic [IrLength-1:0] ir_sr_d, ir_sr_q, ir_d, ir_q;
   logic [31:0] idcode_d, idcode_q;
   logic bypass_d, bypass_q;
   dtmcs_t dtmcs_d, dtmcs_q;
   logic dmi_reset_d, dmi_reset_q, dmi_hardreset_d, dmi_hardreset_q;
   logic idcode_sel_s, dtmcs_sel_s, dmi_sel_s, bypass_sel_s;
   logic [NumChains-1:0] chain_sel_s;
   logic tdo_d, tdo_q, tdo_oe_d, tdo_oe_q;
   logic tck_inv_s, tck_n_s;

   jtag_tap_fsm i_fsm (
      .tck_i              (tck_i),
      .trst_ni            (trst_ni),
      .tms_i              (tms_i),
      .test_logic_reset_o (tlr_s),
      .capture_dr_o       (cap_dr_s),
      .shift_dr_o         (sh_dr_s),
      .update_dr_o        (upd_dr_s),
      .capture_ir_o       (cap_ir_s),
      .shift_ir_o         (sh_ir_s),
      .update_ir_o        (upd_ir_s)
   );

   // Instruction decode from the latched IR; anything undecoded falls through to BYPASS
   always_comb begin
      idcode_sel_s = 1'b0;
      dtmcs_sel_s  = 1'b0;
      dmi_sel_s    = 1'b0;
      case (ir_q)
         IrIdcode: idcode_sel_s = 1'b1;
         IrDtmcs:  dtmcs_sel_s  = 1'b1;
         IrDmi:    dmi_sel_s    = 1'b1;
         default:  idcode_sel_s = 1'b0;
      endcase
      for (int i = 0; i < NumChains; i++) begin
         chain_sel_s[i] = (ir_q == IrLength'(UserIrBase + i));
      end
      bypass_sel_s = ~(idcode_sel_s | dtmcs_sel_s | dmi_sel_s | (|chain_sel_s));
   end

   // IR capture/shift/update
   always_comb begin
      ir_sr_d = ir_sr_q;
      ir_d    = ir_q;
      if (tlr_s) begin
         ir_sr_d = '0;
         ir_d    = IrIdcode;
      end else if (cap_ir_s) begin
         ir_sr_d = IrCapture;
      end else if (sh_ir_s) begin
         ir_sr_d = {td_i, ir_sr_q[IrLength-1:1]};
      end else if (upd_ir_s) begin
         ir_d = ir_sr_q;
      end else begin
         ir_sr_d = ir_sr_q;
      end
   end

   // Internal DR capture/shift and DTMCS write-side pulses
   always_comb begin
      idcode_d = idcode_q;
      bypass_d = bypass_q;
      dtmcs_d  = dtmcs_q;
      if (tlr_s) begin
         idcode_d = IdcodeValue;
         bypass_d = 1'b0;
      end else if (cap_dr_s) begin
         if (idcode_sel_s) idcode_d = IdcodeValue; else idcode_d = idcode_q;
         if (bypass_sel_s) bypass_d = 1'b0;        else bypass_d = bypass_q;
         if (dtmcs_sel_s) begin
            dtmcs_d = '{zero1: 14'd0, dmihardreset: 1'b0, dmireset: 1'b0, zero0: 1'b0,
                        idle: IdleVal, dmistat: dmi_error_i, abits: AbitsVal, version: 4'd1};
         end else begin
            dtmcs_d = dtmcs_q;
         end
      end else if (sh_dr_s) begin
         if (idcode_sel_s) idcode_d = {td_i, idcode_q[31:1]}; else idcode_d = idcode_q;
         if (bypass_sel_s) bypass_d = td_i;                   else bypass_d = bypass_q;
         if (dtmcs_sel_s)  dtmcs_d  = dtmcs_t'({td_i, dtmcs_q[31:1]}); else dtmcs_d = dtmcs_q;
      end else begin
         idcode_d = idcode_q;
      end
      dmi_reset_d     = upd_dr_s & dtmcs_sel_s & dtmcs_q.dmireset;
      dmi_hardreset_d = upd_dr_s & dtmcs_sel_s & dtmcs_q.dmihardreset;
   end

   // Rising-tck datapath registers
   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         ir_sr_q         <= '0;
         ir_q            <= IrIdcode;
         idcode_q        <= IdcodeValue;
         bypass_q        <= 1'b0;
         dtmcs_q         <= '0;
         dmi_reset_q     <= 1'b0;
         dmi_hardreset_q <= 1'b0;
      end else begin
         ir_sr_q         <= ir_sr_d;
         ir_q            <= ir_d;
         idcode_q        <= idcode_d;
         bypass_q        <= bypass_d;
         dtmcs_q         <= dtmcs_d;
         dmi_reset_q     <= dmi_reset_d;
         dmi_hardreset_q <= dmi_hardreset_d;
      end
   end

   // TDO source mux
   always_comb begin
      tdo_d = bypass_q;
      if (sh_ir_s) begin
         tdo_d = ir_sr_q[0];
      end else if (idcode_sel_s) begin
         tdo_d = idcode_q[0];
      end else if (dtmcs_sel_s) begin
         tdo_d = dtmcs_q[0];
      end else if (dmi_sel_s) begin
         tdo_d = dmi_tdo_i;
      end else if (|chain_sel_s) begin
         tdo_d = |(chain_sel_s & chain_tdo_i);
      end else begin
         tdo_d = bypass_q;
      end
      tdo_oe_d = sh_ir_s | sh_dr_s;
   end

   // In DFT mode the TDO stage runs on true tck so scan sees a single clock polarity
   tc_clk_inverter i_tck_inv (
      .clk_i (tck_i),
      .clk_o (tck_inv_s)
   );

   tc_clk_mux2 i_tck_mux (
      .clk0_i    (tck_inv_s),
      .clk1_i    (tck_i),
      .clk_sel_i (testmode_i),
      .clk_o     (tck_n_s)
   );

   // Falling-tck TDO and output-enable registers
   always_ff @(posedge tck_n_s or negedge trst_ni) begin
      if (!trst_ni) begin
         tdo_q    <= 1'b0;
         tdo_oe_q <= 1'b0;
      end else begin
         tdo_q    <= tdo_d;
         tdo_oe_q <= tdo_oe_d;
      end
   end

   assign td_o               = tdo_q;
   assign tdo_oe_o           = tdo_oe_q;
   assign test_logic_reset_o = tlr_s;
   assign capture_dr_o       = cap_dr_s;
   assign shift_dr_o         = sh_dr_s;
   assign update_dr_o        = upd_dr_s;
   assign dmi_access_o       = dmi_sel_s;
   assign dmi_reset_o        = dmi_reset_q;
   assign dmi_hardreset_o    = dmi_hardreset_q;
   assign dmi_tdi_o          = td_i;
   assign chain_select_o     = chain_sel_s;

endmodule
